// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch stall, flush and memory-miss freeze control
// with a saturating stall counter and a sticky memory-timeout flag.
module hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ID_RSaddr_i,
  input  logic [4:0]  ID_RTaddr_i,
  input  logic        ID_Branch_i,
  input  logic        ID_Jump_i,
  input  logic        Eq_i,
  input  logic [1:0]  EX_MemRead_i,
  input  logic        EX_RegWrite_i,
  input  logic [4:0]  EX_WrAddr_i,
  input  logic [1:0]  MEM_MemRead_i,
  input  logic [4:0]  MEM_WrAddr_i,
  input  logic        MEM_Req_i,
  input  logic        DMem_Ready_i,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        Stall_o,
  output logic        IFFlush_o,
  output logic        Freeze_o,
  output logic [15:0] StallCnt_o,
  output logic        Err_o
);

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  wcnt_q;
  logic [15:0] cnt_q;
  logic        err_q;

  logic ex_hit;
  logic mem_hit;
  logic lu;
  logic bh;
  logic miss;
  logic frz;
  logic wait_tick;

  assign ex_hit = (EX_WrAddr_i != 5'd0) &&
                  ((EX_WrAddr_i == ID_RSaddr_i) ||
                   (EX_WrAddr_i == ID_RTaddr_i));

  assign mem_hit = (MEM_WrAddr_i != 5'd0) &&
                   ((MEM_WrAddr_i == ID_RSaddr_i) ||
                    (MEM_WrAddr_i == ID_RTaddr_i));

  assign lu = (EX_MemRead_i != 2'd0) && ex_hit;

  assign bh = ID_Branch_i &&
              ((EX_RegWrite_i && ex_hit) ||
               ((MEM_MemRead_i != 2'd0) && mem_hit));

  assign miss = MEM_Req_i & ~DMem_Ready_i;

  assign wait_tick = (state_q == MEMWAIT) && !DMem_Ready_i;

  // next state and freeze condition
  always_comb begin
    state_d = state_q;
    frz     = 1'b0;
    case (state_q)
      RUN: begin
        frz = miss;
        if (miss) state_d = MEMWAIT;
      end
      MEMWAIT: begin
        frz = ~DMem_Ready_i;
        if (DMem_Ready_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // pipeline control, priority freeze > stall > flush, all off in reset
  always_comb begin
    PCWrite_o   = 1'b0;
    IFIDWrite_o = 1'b0;
    Stall_o     = 1'b0;
    IFFlush_o   = 1'b0;
    Freeze_o    = 1'b0;
    if (rst_i) begin
      Freeze_o = 1'b0;
    end else if (frz) begin
      Freeze_o = 1'b1;
    end else if (lu || bh) begin
      Stall_o = 1'b1;
    end else begin
      PCWrite_o   = 1'b1;
      IFIDWrite_o = 1'b1;
      IFFlush_o   = ID_Jump_i | (ID_Branch_i & Eq_i);
    end
  end

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // memory wait counter, cleared on entry, saturates at 255
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wcnt_q <= 8'd0;
    end else if ((state_q == RUN) && miss) begin
      wcnt_q <= 8'd0;
    end else if (wait_tick && (wcnt_q != 8'hFF)) begin
      wcnt_q <= wcnt_q + 8'd1;
    end
  end

  // sticky timeout flag, set as the wait counter reaches 255
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (wait_tick && (wcnt_q == 8'hFE)) begin
      err_q <= 1'b1;
    end
  end

  // saturating count of stall and freeze cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 16'd0;
    end else if ((Freeze_o || Stall_o) && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign StallCnt_o = cnt_q;
  assign Err_o      = err_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high; ports clk_i, rst_i.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ID_RSaddr_i, ID_RTaddr_i  in  5  source register addresses of the instruction in ID
- ID_Branch_i, ID_Jump_i  in  1  ID-stage branch / jump decode
- Eq_i  in  1  ID register-compare result
- EX_MemRead_i  in  2  EX-stage load access code; nonzero means load
- EX_RegWrite_i  in  1  EX-stage write-back enable
- EX_WrAddr_i  in  5  EX-stage destination register
- MEM_MemRead_i  in  2  MEM-stage load access code
- MEM_WrAddr_i  in  5  MEM-stage destination register
- MEM_Req_i  in  1  MEM stage accesses data memory this cycle
- DMem_Ready_i  in  1  data memory completes the access this cycle
- PCWrite_o, IFIDWrite_o  out  1  PC / IF-ID register update enable
- Stall_o  out  1  drives the ID Control Stall_i input; inserts a bubble into ID/EX
- IFFlush_o  out  1  zeroes the IF/ID register on the next edge
- Freeze_o  out  1  holds ID/EX, EX/MEM and MEM/WB registers
- StallCnt_o  out  16  saturating count of stall/freeze cycles
- Err_o  out  1  sticky memory-timeout flag

Function
REQ-003 SHALL implement FSM states RUN and MEMWAIT; state, wait counter, StallCnt_o and Err_o are the only registers.
REQ-004 SHALL treat register address 0 as never matching for all hazard comparisons.
REQ-005 SHALL raise load-use hazard LU when EX_MemRead_i != 0 and EX_WrAddr_i matches ID_RSaddr_i or ID_RTaddr_i.
REQ-006 SHALL raise branch hazard BH when ID_Branch_i = 1 and either condition holds:
- EX_RegWrite_i = 1 and EX_WrAddr_i matches RS or RT.
- MEM_MemRead_i != 0 and MEM_WrAddr_i matches RS or RT.
REQ-007 SHALL define MISS = MEM_Req_i AND NOT DMem_Ready_i.
REQ-008 SHALL define FRZ as follows:
- In RUN, FRZ = MISS.
- In MEMWAIT, FRZ = NOT DMem_Ready_i.
REQ-009 SHALL drive outputs combinationally in the same cycle, with priority FRZ > (LU or BH) > flush.
REQ-010 When FRZ = 1, SHALL drive Freeze_o = 1, PCWrite_o = 0, IFIDWrite_o = 0, Stall_o = 0 and IFFlush_o = 0.
REQ-011 When FRZ = 0 and (LU or BH) = 1, SHALL drive Stall_o = 1, PCWrite_o = 0, IFIDWrite_o = 0, IFFlush_o = 0 and Freeze_o = 0.
REQ-012 When no freeze or stall applies, SHALL drive IFFlush_o = ID_Jump_i OR (ID_Branch_i AND Eq_i), with PCWrite_o = 1 and IFIDWrite_o = 1.
REQ-013 SHALL produce the correct stall count per hazard, re-evaluating every cycle with no extra state:
- Load followed by a dependent branch: two stall cycles (EX match, then MEM match).
- ALU result followed by a dependent branch: one stall cycle.
- Load followed by a dependent non-branch instruction: one stall cycle.
REQ-014 SHALL follow these FSM transitions:
- RUN to MEMWAIT when MISS = 1.
- MEMWAIT to RUN in the cycle DMem_Ready_i = 1.
- Otherwise hold the current state.
REQ-015 SHALL manage the 8-bit wait counter as follows:
- Cleared on entering MEMWAIT.
- Increments each MEMWAIT cycle with DMem_Ready_i = 0, saturating at 255.
- When it reaches 255, sets Err_o = 1; Err_o stays set until reset.
- State remains MEMWAIT until DMem_Ready_i = 1.
REQ-016 SHALL increment StallCnt_o on each clock edge where Freeze_o or Stall_o was 1, saturating at 16'hFFFF with no wrap.
REQ-017 SHALL handle simultaneous events as follows:
- LU/BH during FRZ are masked, and re-evaluated once FRZ drops.
- A taken branch or jump during a stall or freeze produces no flush until the stall/freeze clears.

Reset
REQ-018 While rst_i = 1 at a clock edge, SHALL set state RUN, wait counter 0, StallCnt_o 0 and Err_o 0.
REQ-019 SHALL override state while rst_i = 1: PCWrite_o = 0, IFIDWrite_o = 0, Stall_o = 0, Freeze_o = 0 and IFFlush_o = 0.
REQ-020 SHALL treat reset asserted in MEMWAIT identically, returning to RUN on the next edge.

Verification
REQ-021 Load-use: EX_MemRead=3, EX_WrAddr=5, ID_RS=5 -> one cycle of Stall_o=1 and PCWrite_o=0; next cycle (EX bubble) Stall_o=0; StallCnt_o=1.
REQ-022 Load then branch: EX load to r8, ID_Branch=1, ID_RT=8 -> Stall_o=1 for two cycles (EX match, then MEM match); then with Eq_i=1 -> IFFlush_o=1 for one cycle; StallCnt_o=2.
REQ-023 Memory miss: MEM_Req_i=1, DMem_Ready_i low for 3 cycles then high -> Freeze_o=1 for 3 cycles and 0 in the ready cycle; state back in RUN; StallCnt_o=3.
REQ-024 Timeout: DMem_Ready_i held low for 300 cycles -> Err_o=1 from wait count 255 onward; Freeze_o stays 1; Err_o persists after ready.
REQ-025 Zero register and priority:
- EX load to r0 with ID_RS=0 -> no stall.
- Simultaneous MISS and LU -> only Freeze_o=1.
- Jump during freeze -> IFFlush_o=0.
REQ-026 Reset mid-MEMWAIT: rst_i=1 for one edge -> state RUN; StallCnt_o=0; Err_o=0; all stall/flush/freeze outputs 0 while rst_i=1.
